gfx_pixel_writer: RTL and testbench

Downstream stage of the line rasterizer. Accepts a stream of framebuffer pixel coordinates plus colour, computes the linear framebuffer address `y*FB_WIDTH + x` in a registered stage, and buffers the results in a small FIFO. The FIFO drains to the framebuffer memory through a request/acknowledge write port. Its `pixel_ready` output drives the rasterizer's `enable`, so backpressure from memory stalls line stepping without losing pixels.

---
 rtl/gfx_pixel_writer.sv | 119 +++++++++++
 tb/tb_gfx_pixel_writer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_pixel_writer.sv
// gfx_pixel_writer: address stage plus first-word-fall-through write FIFO between rasterizer and framebuffer.
// Optional build macro GFX_PIXEL_WRITER_CLIP_EN drops off-screen pixels at acceptance.

`ifndef VGA_MODE_H_VISIBLE
`define VGA_MODE_H_VISIBLE 640
`endif
`ifndef VGA_MODE_V_VISIBLE
`define VGA_MODE_V_VISIBLE 480
`endif

module gfx_pixel_writer #(
  parameter int unsigned FB_WIDTH   = `VGA_MODE_H_VISIBLE,
  parameter int unsigned FB_HEIGHT  = `VGA_MODE_V_VISIBLE,
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned FB_X_BITS = $clog2(FB_WIDTH),
  localparam int unsigned FB_Y_BITS = $clog2(FB_HEIGHT),
  localparam int unsigned ADDR_BITS = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pixel_valid,
  input  logic [FB_X_BITS-1:0]  pixel_x,
  input  logic [FB_Y_BITS-1:0]  pixel_y,
  input  logic [COLOR_BITS-1:0] pixel_color,
  output logic                  pixel_ready,
  output logic                  mem_req,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [COLOR_BITS-1:0] mem_data,
  input  logic                  mem_ack,
  output logic                  idle,
  output logic [15:0]           pix_count
);

  localparam int unsigned IDX_BITS = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_BITS = IDX_BITS + 1;

  typedef struct packed {
    logic [ADDR_BITS-1:0]  addr;
    logic [COLOR_BITS-1:0] color;
  } wr_entry_t;

  logic                stg_valid;
  wr_entry_t           stg_q;
  wr_entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 accept;
  logic                 in_range;
  logic                 load;
  logic                 push;
  logic                 pop;
  logic [ADDR_BITS-1:0] pix_addr;

  // Pointer MSB differs only when the write side has lapped the read side.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_BITS-1] != rd_ptr[PTR_BITS-1]) &&
                      (wr_ptr[IDX_BITS-1:0] == rd_ptr[IDX_BITS-1:0]);

  // Ready depends on registers only, so memory backpressure never forms a comb loop upstream.
  assign pixel_ready = !stg_valid || !fifo_full;
  assign accept      = pixel_valid && pixel_ready;
  assign push        = stg_valid && !fifo_full;
  assign pop         = mem_req && mem_ack;

`ifdef GFX_PIXEL_WRITER_CLIP_EN
  assign in_range = (32'(pixel_x) < FB_WIDTH) && (32'(pixel_y) < FB_HEIGHT);
`else
  assign in_range = 1'b1;
`endif

  assign load     = accept && in_range;
  assign pix_addr = ADDR_BITS'(ADDR_BITS'(pixel_y) * ADDR_BITS'(FB_WIDTH) + ADDR_BITS'(pixel_x));

  // Address stage: reload on accept, otherwise empty once its entry moves into the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_valid <= 1'b0;
      stg_q     <= '0;
    end else if (load) begin
      stg_valid <= 1'b1;
      stg_q     <= '{addr: pix_addr, color: pixel_color};
    end else if (push) begin
      stg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[IDX_BITS-1:0]] <= stg_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pix_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_BITS'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_BITS'(1);
        pix_count <= pix_count + 16'd1;
      end
    end
  end

  // Head is masked while empty so unreset storage never reaches the memory port.
  assign mem_req  = !fifo_empty;
  assign mem_addr = fifo_empty ? '0 : fifo_mem[rd_ptr[IDX_BITS-1:0]].addr;
  assign mem_data = fifo_empty ? '0 : fifo_mem[rd_ptr[IDX_BITS-1:0]].color;
  assign idle     = !stg_valid && fifo_empty;

endmodule

// File: tb/tb_gfx_pixel_writer.sv
// tb_gfx_pixel_writer: directed scenarios plus random traffic, checked by a queue scoreboard.
// The reference model tracks pixels held by the block and their acceptance cycle.

module tb_gfx_pixel_writer;

  localparam int unsigned W  = 640;
  localparam int unsigned H  = 480;
  localparam int unsigned CB = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned XB = 10;
  localparam int unsigned YB = 9;
  localparam int unsigned AB = 19;

  logic          clk = 1'b0;
  logic          reset;
  logic          pixel_valid;
  logic [XB-1:0] pixel_x;
  logic [YB-1:0] pixel_y;
  logic [CB-1:0] pixel_color;
  logic          pixel_ready;
  logic          mem_req;
  logic [AB-1:0] mem_addr;
  logic [CB-1:0] mem_data;
  logic          mem_ack;
  logic          idle;
  logic [15:0]   pix_count;

  gfx_pixel_writer dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_valid(pixel_valid),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .pixel_color(pixel_color),
    .pixel_ready(pixel_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack),
    .idle       (idle),
    .pix_count  (pix_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    int unsigned color;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned exp_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  function automatic bit keep_pixel(input int unsigned x, input int unsigned y);
`ifdef GFX_PIXEL_WRITER_CLIP_EN
    return (x < W) && (y < H);
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: every pixel held by the block is in sb; the head is visible to memory one cycle after its accepting edge.
  always @(negedge clk) begin
    bit   req_exp;
    exp_t e;
    if (reset) begin
      sb.delete();
      exp_count = 0;
    end else begin
      req_exp = (sb.size() > 0) && (cyc >= sb[0].acc + 1);
      chk("pixel_ready", 32'(pixel_ready), 32'(sb.size() < D + 1));
      chk("idle", 32'(idle), 32'(sb.size() == 0));
      chk("mem_req", 32'(mem_req), 32'(req_exp));
      chk("pix_count", 32'(pix_count), exp_count % 65536);
      if (req_exp && mem_req) begin
        chk("mem_addr", 32'(mem_addr), sb[0].addr);
        chk("mem_data", 32'(mem_data), sb[0].color);
      end
      if (req_exp && mem_ack) begin
        void'(sb.pop_front());
        exp_count++;
      end
      if (pixel_valid && pixel_ready && keep_pixel(32'(pixel_x), 32'(pixel_y))) begin
        e.addr  = (32'(pixel_y) * W + 32'(pixel_x)) % (1 << AB);
        e.color = 32'(pixel_color);
        e.acc   = cyc + 1;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input int unsigned x, input int unsigned y, input int unsigned c);
    bit ok;
    bit done;
    done        = 1'b0;
    pixel_x     = XB'(x);
    pixel_y     = YB'(y);
    pixel_color = CB'(c);
    pixel_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      ok = pixel_ready;
      @(posedge clk);
      #1;
      if (ok) done = 1'b1;
    end
    pixel_valid = 1'b0;
    chk("send_accept", 32'(done), 32'd1);
  endtask

  task automatic wait_drain();
    bit drained;
    drained = 1'b0;
    for (int k = 0; k < 300 && !drained; k++) begin
      if (sb.size() == 0 && idle) drained = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("drain", 32'(drained), 32'd1);
  endtask

  initial begin
    int  acc;
    int  i;
    bit  stalled;
    reset       = 1'b1;
    pixel_valid = 1'b0;
    pixel_x     = '0;
    pixel_y     = '0;
    pixel_color = '0;
    mem_ack     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_ready", 32'(pixel_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_count", 32'(pix_count), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single pixel latency.
    mem_ack = 1'b1;
    send(3, 2, 'hA);
    chk("lat_n1_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_req", 32'(mem_req), 32'd1);
    chk("lat_addr", 32'(mem_addr), 32'd1283);
    chk("lat_data", 32'(mem_data), 32'hA);
    wait_drain();
    chk("single_count", 32'(pix_count), 32'd1);
    chk("single_idle", 32'(idle), 32'd1);

    // Back-to-back stream with memory always accepting.
    stalled = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!pixel_ready) stalled = 1'b1;
      send(k, 0, k);
    end
    chk("stream_no_stall", 32'(stalled), 32'd0);
    wait_drain();
    chk("stream_count", 32'(pix_count), 32'd11);

    // Capacity with memory stalled, then a single-cycle ack pulse.
    mem_ack = 1'b0;
    acc = 0;
    i   = 0;
    for (int k = 0; k < 10; k++) begin
      pixel_x     = XB'(i);
      pixel_y     = YB'(5);
      pixel_color = CB'(i + 1);
      pixel_valid = 1'b1;
      if (pixel_ready) begin
        acc++;
        i++;
      end
      @(posedge clk);
      #1;
    end
    pixel_valid = 1'b0;
    chk("capacity", 32'(acc), D + 1);
    chk("full_ready", 32'(pixel_ready), 32'd0);
    chk("hold_addr", 32'(mem_addr), 32'd3200);
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    chk("pulse_ready", 32'(pixel_ready), 32'd1);
    chk("pulse_count", 32'(pix_count), 32'd12);
    chk("pulse_next_addr", 32'(mem_addr), 32'd3201);
    repeat (3) @(posedge clk);
    #1;
    mem_ack = 1'b1;
    wait_drain();
    chk("cap_count", 32'(pix_count), 32'd16);

    // Bottom-right corner pixel.
    send(639, 479, 5);
    wait_drain();
    chk("corner_count", 32'(pix_count), 32'd17);

`ifdef GFX_PIXEL_WRITER_CLIP_EN
    send(640, 0, 3);
    repeat (4) @(posedge clk);
    #1;
    chk("clip_req", 32'(mem_req), 32'd0);
    chk("clip_count", 32'(pix_count), 32'd17);
`endif

    // Reset with pixels buffered.
    mem_ack = 1'b0;
    send(10, 10, 1);
    send(11, 10, 2);
    send(12, 10, 3);
    reset = 1'b1;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_idle", 32'(idle), 32'd1);
    chk("midrst_count", 32'(pix_count), 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    mem_ack = 1'b1;
    send(1, 1, 7);
    @(posedge clk);
    #1;
    chk("post_rst_addr", 32'(mem_addr), 32'd641);
    wait_drain();
    chk("post_rst_count", 32'(pix_count), 32'd1);

    // Random traffic and random backpressure.
    for (int k = 0; k < 800; k++) begin
      pixel_valid = ($urandom_range(0, 9) < 7);
      pixel_x     = XB'($urandom_range(0, 700));
      pixel_y     = YB'($urandom_range(0, 511));
      pixel_color = CB'($urandom);
      mem_ack     = ($urandom_range(0, 9) < 6);
      @(posedge clk);
      #1;
    end
    pixel_valid = 1'b0;
    mem_ack     = 1'b1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
